// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the multiport register file.
// Types here describe the default configuration; parametrised modules size their own signals.
package rf_pkg;

    localparam int              DEF_XLEN    = 32;
    localparam int              DEF_NREGS   = 32;
    localparam logic [31:0]     DEF_SP_INIT = 32'h2ffc;
    localparam int              DEF_AW      = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xdata_t;

    // Low bit of port k's slice in a flattened bus of w-bit fields.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, with issue winning on a tie.
// Register 0 is never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    // A new producer overrides the retiring one, so set takes priority over clear.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (iss_en && (iss_addr == AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// Architectural register file with NRD combinational read ports, write-to-read bypass,
// hardwired zero register and a busy scoreboard for RAW hazard detection.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int              XLEN    = DEF_XLEN,
    parameter int              NREGS   = DEF_NREGS,
    parameter int              NRD     = 2,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(DEF_SP_INIT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]    rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   iss_en,
    input  logic [$clog2(NREGS)-1:0] iss_addr,
    output logic [NREGS-1:0]       busy_vec,
    output logic [NREGS*XLEN-1:0]  print_reg
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_valid;

    assign w_wr_valid = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = rd_addr[slice_lo(k, AW) +: AW];

        // A value arriving this cycle is forwarded and is no longer pending.
        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = busy_vec[w_addr];
            if (w_addr == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if (w_wr_valid && (wr_addr == w_addr)) begin
                w_data = wr_data;
                w_busy = 1'b0;
            end
        end

        assign rd_data[slice_lo(k, XLEN) +: XLEN] = w_data;
        assign rd_busy[k]                         = w_busy;
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_print
        if (i == 0) begin : g_zero
            assign print_reg[0 +: XLEN] = '0;
        end else begin : g_reg
            assign print_reg[i*XLEN +: XLEN] = r_regs[i];
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file: a default 32x32 2-port instance
// and a 16x64 4-port instance sharing clock and reset.
module tb_multiport_register_file;

    logic          clk;
    logic          reset;

    logic [9:0]    rdAddr;
    logic [63:0]   rdData;
    logic [1:0]    rdBusy;
    logic          wrEn;
    logic [4:0]    wrAddr;
    logic [31:0]   wrData;
    logic          issEn;
    logic [4:0]    issAddr;
    logic [31:0]   busyVec;
    logic [1023:0] printReg;

    logic [15:0]   rdAddr4;
    logic [255:0]  rdData4;
    logic [3:0]    rdBusy4;
    logic          wrEn4;
    logic [3:0]    wrAddr4;
    logic [63:0]   wrData4;
    logic          issEn4;
    logic [3:0]    issAddr4;
    logic [15:0]   busyVec4;
    logic [1023:0] printReg4;

    int testsRun;
    int testsFailed;

    multiport_register_file dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .rd_busy   (rdBusy),
        .wr_en     (wrEn),
        .wr_addr   (wrAddr),
        .wr_data   (wrData),
        .iss_en    (issEn),
        .iss_addr  (issAddr),
        .busy_vec  (busyVec),
        .print_reg (printReg)
    );

    multiport_register_file #(
        .XLEN    (64),
        .NREGS   (16),
        .NRD     (4),
        .SP_IDX  (2),
        .SP_INIT (64'h2ffc)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rdAddr4),
        .rd_data   (rdData4),
        .rd_busy   (rdBusy4),
        .wr_en     (wrEn4),
        .wr_addr   (wrAddr4),
        .wr_data   (wrData4),
        .iss_en    (issEn4),
        .iss_addr  (issAddr4),
        .busy_vec  (busyVec4),
        .print_reg (printReg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge so every check sits well away from it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wrEn = 1'b0; wrAddr = '0; wrData = '0;
        issEn = 1'b0; issAddr = '0;
        wrEn4 = 1'b0; wrAddr4 = '0; wrData4 = '0;
        issEn4 = 1'b0; issAddr4 = '0;
    endtask

    task automatic test_reset();
        logic [31:0] expSlice;
        nextCycle();
        wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h77;
        issEn = 1'b1; issAddr = 5'd6;
        nextCycle();
        idleInputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            expSlice = (i == 2) ? 32'h2ffc : 32'h0;
            testsRun++;
            if (printReg[i*32 +: 32] !== expSlice) begin
                testsFailed++;
                $display("[TB] FAIL reset_slice%0d got %h want %h", i, printReg[i*32 +: 32], expSlice);
            end
        end
        testsRun++;
        if (busyVec !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy got %h want 0", busyVec);
        end
        rdAddr = {5'd0, 5'd2};
        #1;
        testsRun++;
        if (rdData[31:0] !== 32'h2ffc) begin
            testsFailed++;
            $display("[TB] FAIL reset_read_sp got %h want 2ffc", rdData[31:0]);
        end
        reset = 1'b1;
    endtask

    task automatic test_write_read_x0();
        nextCycle();
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF;
        nextCycle();
        wrAddr = 5'd0; wrData = 32'h1234;
        nextCycle();
        idleInputs();
        rdAddr = {5'd5, 5'd5};
        #1;
        for (int k = 0; k < 2; k++) begin
            testsRun++;
            if (rdData[k*32 +: 32] !== 32'hDEADBEEF) begin
                testsFailed++;
                $display("[TB] FAIL read_x5_port%0d got %h want deadbeef", k, rdData[k*32 +: 32]);
            end
        end
        rdAddr = {5'd0, 5'd0};
        #1;
        for (int k = 0; k < 2; k++) begin
            testsRun++;
            if (rdData[k*32 +: 32] !== 32'h0 || rdBusy[k] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL read_x0_port%0d got data %h busy %b want 0 0", k, rdData[k*32 +: 32], rdBusy[k]);
            end
        end
        testsRun++;
        if (printReg[31:0] !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL x0_stored got %h want 0", printReg[31:0]);
        end
    endtask

    task automatic test_bypass();
        nextCycle();
        rdAddr = {5'd7, 5'd0};
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hA5A5A5A5;
        #1;
        testsRun++;
        if (rdData[63:32] !== 32'hA5A5A5A5 || rdBusy[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bypass_port1 got data %h busy %b want a5a5a5a5 0", rdData[63:32], rdBusy[1]);
        end
        testsRun++;
        if (printReg[7*32 +: 32] !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL bypass_early_store got %h want 0", printReg[7*32 +: 32]);
        end
        nextCycle();
        idleInputs();
        testsRun++;
        if (printReg[7*32 +: 32] !== 32'hA5A5A5A5) begin
            testsFailed++;
            $display("[TB] FAIL bypass_store got %h want a5a5a5a5", printReg[7*32 +: 32]);
        end
    endtask

    task automatic test_scoreboard();
        issEn = 1'b1; issAddr = 5'd9;
        nextCycle();
        idleInputs();
        rdAddr = {5'd0, 5'd9};
        #1;
        testsRun++;
        if (busyVec[9] !== 1'b1 || rdBusy[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sb_issue got busy_vec9 %b rd_busy %b want 1 1", busyVec[9], rdBusy[0]);
        end
        nextCycle();
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h42;
        #1;
        testsRun++;
        if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h42) begin
            testsFailed++;
            $display("[TB] FAIL sb_write_cycle got busy %b data %h want 0 42", rdBusy[0], rdData[31:0]);
        end
        nextCycle();
        idleInputs();
        testsRun++;
        if (busyVec[9] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sb_cleared got %b want 0", busyVec[9]);
        end
        issEn = 1'b1; issAddr = 5'd0;
        nextCycle();
        idleInputs();
        testsRun++;
        if (busyVec !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL sb_issue_x0 got %h want 0", busyVec);
        end
    endtask

    task automatic test_set_and_clear();
        issEn = 1'b1; issAddr = 5'd3;
        nextCycle();
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h11;
        nextCycle();
        idleInputs();
        rdAddr = {5'd3, 5'd0};
        #1;
        testsRun++;
        if (busyVec[3] !== 1'b1 || rdBusy[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL setclr_busy got busy_vec3 %b rd_busy %b want 1 1", busyVec[3], rdBusy[1]);
        end
        testsRun++;
        if (printReg[3*32 +: 32] !== 32'h11) begin
            testsFailed++;
            $display("[TB] FAIL setclr_data got %h want 11", printReg[3*32 +: 32]);
        end
    endtask

    task automatic test_param_sweep();
        logic [63:0] expData [4];
        expData[0] = 64'hFFFF_0000_FFFF_0000;
        expData[1] = 64'hFFFF_0000_FFFF_0000;
        expData[2] = 64'h1;
        expData[3] = 64'h0;
        nextCycle();
        wrEn4 = 1'b1; wrAddr4 = 4'd1; wrData4 = 64'hFFFF_0000_FFFF_0000;
        nextCycle();
        wrAddr4 = 4'd15; wrData4 = 64'h1;
        nextCycle();
        idleInputs();
        rdAddr4 = {4'd0, 4'd15, 4'd1, 4'd1};
        #1;
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if (rdData4[k*64 +: 64] !== expData[k]) begin
                testsFailed++;
                $display("[TB] FAIL sweep_port%0d got %h want %h", k, rdData4[k*64 +: 64], expData[k]);
            end
        end
        testsRun++;
        if (printReg4[2*64 +: 64] !== 64'h2ffc) begin
            testsFailed++;
            $display("[TB] FAIL sweep_sp got %h want 2ffc", printReg4[2*64 +: 64]);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        rdAddr      = '0;
        rdAddr4     = '0;
        idleInputs();
        #12;
        reset = 1'b1;

        test_reset();
        test_write_read_x0();
        test_bypass();
        test_scoreboard();
        test_set_and_clear();
        test_param_sweep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
